// File: rtl/pixel_cache.sv
// pixel_cache: single-bit pixel read port for the edge search engine, backed by
// a small direct-mapped cache of binary frame-buffer words.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   x, y, request        requested pixel coordinate; request held until ready
//   pixel, ready         pixel value, valid during the one-cycle ready pulse
//   invalidate           frame-swap pulse; drops all cached lines
//   mem_addr, mem_rd     frame-buffer word address and one-cycle read strobe
//   mem_rdata, mem_valid returned word and its one-cycle valid pulse
//   miss_count           saturating count of memory fetches since reset
module pixel_cache #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned LINES  = 4,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              request,
  output logic              pixel,
  output logic              ready,
  input  logic              invalidate,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       miss_count
);

  localparam int unsigned XY_W   = 10;
  localparam int unsigned IDX_W  = 19;
  localparam int unsigned OFF_W  = $clog2(WORD_W);
  localparam int unsigned LINE_W = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_W - LINE_W;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FETCH,
    S_WAIT,
    S_RESPOND
  } state_e;

  state_e              state_q, state_d;
  logic [XY_W-1:0]     x_q, x_d, y_q, y_d;
  logic                ready_q, ready_d;
  logic                pixel_q, pixel_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]    miss_q, miss_d;
  logic                pend_q, pend_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [WORD_W-1:0]   data_q [LINES];

  logic [IDX_W-1:0]    idx;
  logic [ADDR_W-1:0]   waddr;
  logic [OFF_W-1:0]    bit_sel;
  logic [LINE_W-1:0]   line_idx;
  logic [TAG_W-1:0]    tag;
  logic                oor;
  logic                hit;
  logic                fill_we;
  logic                fill_valid;
  logic                clear_all;

  // Address decomposition of the latched coordinate
  always_comb begin
    idx      = IDX_W'(y_q) * IDX_W'(IMG_W) + IDX_W'(x_q);
    waddr    = ADDR_W'(idx >> OFF_W);
    bit_sel  = idx[OFF_W-1:0];
    line_idx = waddr[LINE_W-1:0];
    tag      = waddr[ADDR_W-1:LINE_W];
    oor      = (x_q >= XY_W'(IMG_W)) || (y_q >= XY_W'(IMG_H));
    // A coincident invalidate forces the lookup to miss
    hit      = valid_q[line_idx] && (tag_q[line_idx] == tag) && !invalidate;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    ready_d    = 1'b0;
    pixel_d    = pixel_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    miss_d     = miss_q;
    pend_d     = pend_q;
    fill_we    = 1'b0;
    fill_valid = 1'b0;
    clear_all  = 1'b0;

    case (state_q)
      S_IDLE: begin
        clear_all = invalidate;
        if (request) begin
          x_d     = x;
          y_d     = y;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        clear_all = invalidate;
        if (oor) begin
          pixel_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_RESPOND;
        end else if (hit) begin
          pixel_d = data_q[line_idx][bit_sel];
          ready_d = 1'b1;
          state_d = S_RESPOND;
        end else begin
          // Strobe and count are registered on entry so they line up with FETCH
          mem_rd_d   = 1'b1;
          mem_addr_d = waddr;
          if (miss_q != {CNT_W{1'b1}}) begin
            miss_d = miss_q + CNT_W'(1);
          end
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (invalidate) begin
          pend_d = 1'b1;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (invalidate) begin
          pend_d = 1'b1;
        end
        if (mem_valid) begin
          // Line is filled but left invalid if a frame swap happened mid-fill
          fill_we    = 1'b1;
          fill_valid = !(pend_q || invalidate);
          pixel_d    = mem_rdata[bit_sel];
          ready_d    = 1'b1;
          state_d    = S_RESPOND;
        end
      end
      S_RESPOND: begin
        clear_all = pend_q || invalidate;
        pend_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      ready_q    <= 1'b0;
      pixel_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      miss_q     <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      ready_q    <= ready_d;
      pixel_q    <= pixel_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      miss_q     <= miss_d;
      pend_q     <= pend_d;
    end
  end

  // Line valid bits
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[line_idx] <= fill_valid;
    end
  end

  // Line tag and data storage
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[line_idx] <= mem_rdata;
      tag_q[line_idx]  <= tag;
    end
  end

  assign pixel      = pixel_q;
  assign ready      = ready_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_pixel_cache.sv
// tb_pixel_cache: randomized self-checking bench for pixel_cache against a
// whole-word-address cache model and a random-latency frame-buffer responder.
module tb_pixel_cache;

  localparam int IMG_W  = 640;
  localparam int IMG_H  = 480;
  localparam int WORD_W = 16;
  localparam int LINES  = 4;
  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [9:0]        x, y;
  logic              request;
  logic              pixel, ready;
  logic              invalidate;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_valid;
  logic [15:0]       miss_count;

  logic              resp_valid, stray_valid;
  logic [WORD_W-1:0] resp_data, stray_data;

  assign mem_valid = resp_valid | stray_valid;
  assign mem_rdata = stray_valid ? stray_data : resp_data;

  pixel_cache dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .request    (request),
    .pixel      (pixel),
    .ready      (ready),
    .invalidate (invalidate),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WORD_W-1:0] fb [0:32767];
  int  lat = 1;
  bit  resp_en = 1'b1;
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  mline [LINES];
  int  exp_miss = 0;

  // Frame-buffer responder: answers each strobe after 'lat' cycles
  initial begin
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      if (resp_en && mem_rd === 1'b1) begin
        int a;
        int l;
        a = int'(mem_addr);
        l = lat;
        repeat (l) @(posedge clk);
        #1;
        resp_valid = 1'b1;
        resp_data  = fb[a];
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
      end
    end
  end

  task automatic model_clear();
    foreach (mline[i]) mline[i] = -1;
  endtask

  // One request/response transaction, checked against the model
  task automatic run_req(input int rx, input int ry, input bit keep,
                         input int inv_at, input int force_lat);
    int c0, rel, idx, w, b, exp_lat, rd_n, rd_rel, rd_addr, got_rel;
    bit inr, exp_hit, exp_fetch, got, got_pix, exp_pix;
    logic [WORD_W-1:0] wd;
    @(posedge clk);
    #1;
    total_cnt++;
    if (ready !== 1'b0 || mem_rd !== 1'b0) begin
      $display("FAIL idle_quiet (%0d,%0d): ready=%b mem_rd=%b expected 0/0", rx, ry, ready, mem_rd);
    end else pass_cnt++;

    lat     = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
    x       = 10'(rx);
    y       = 10'(ry);
    request = 1'b1;
    c0      = cyc;

    idx = ry * IMG_W + rx;
    inr = (rx < IMG_W) && (ry < IMG_H);
    w   = idx / WORD_W;
    b   = idx % WORD_W;
    if (inv_at == 1) model_clear();
    exp_hit   = inr && (mline[w % LINES] == w);
    exp_fetch = inr && !exp_hit;
    wd        = inr ? fb[w] : '0;
    exp_pix   = inr ? wd[b] : 1'b0;
    exp_lat   = exp_fetch ? 3 + lat : 2;

    got = 0; rd_n = 0; rd_rel = -1; rd_addr = -1; got_rel = -1; got_pix = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk);
      #1;
      rel = cyc - c0;
      if (rel == 1) begin
        x = 10'($urandom);
        y = 10'($urandom);
      end
      invalidate = (inv_at != 0 && rel == inv_at);
      if (mem_rd === 1'b1) begin
        rd_n++;
        rd_rel  = rel;
        rd_addr = int'(mem_addr);
      end
      if (ready === 1'b1) begin
        got     = 1;
        got_rel = rel;
        got_pix = pixel;
        if (!keep) request = 1'b0;
      end
    end
    invalidate = 1'b0;

    total_cnt++;
    if (!got) begin
      $display("FAIL timeout (%0d,%0d): no ready within 200 cycles", rx, ry);
      request = 1'b0;
      return;
    end else pass_cnt++;

    if (exp_fetch && exp_miss < 65535) exp_miss++;

    total_cnt++;
    if (got_rel !== exp_lat) $display("FAIL latency (%0d,%0d): got %0d expected %0d", rx, ry, got_rel, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (got_pix !== exp_pix) $display("FAIL pixel (%0d,%0d): got %0d expected %0d", rx, ry, got_pix, exp_pix);
    else pass_cnt++;
    total_cnt++;
    if (rd_n !== (exp_fetch ? 1 : 0)) $display("FAIL fetch_count (%0d,%0d): got %0d expected %0d", rx, ry, rd_n, exp_fetch ? 1 : 0);
    else pass_cnt++;
    if (exp_fetch) begin
      total_cnt++;
      if (rd_rel !== 2) $display("FAIL rd_cycle (%0d,%0d): got %0d expected 2", rx, ry, rd_rel);
      else pass_cnt++;
      total_cnt++;
      if (rd_addr !== w) $display("FAIL mem_addr (%0d,%0d): got %0d expected %0d", rx, ry, rd_addr, w);
      else pass_cnt++;
    end
    total_cnt++;
    if (int'(miss_count) !== exp_miss) $display("FAIL miss_count (%0d,%0d): got %0d expected %0d", rx, ry, miss_count, exp_miss);
    else pass_cnt++;

    if (exp_fetch) begin
      if (inv_at >= 2) model_clear();
      else mline[w % LINES] = w;
    end
  endtask

  task automatic pulse_inv();
    @(posedge clk);
    #1 invalidate = 1'b1;
    @(posedge clk);
    #1 invalidate = 1'b0;
    model_clear();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    exp_miss = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; request = 1'b0; invalidate = 1'b0; x = '0; y = '0;
    stray_valid = 1'b0; stray_data = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", ready); else pass_cnt++;
    total_cnt++; if (pixel !== 1'b0) $display("FAIL rst_pixel: got %b expected 0", pixel); else pass_cnt++;
    total_cnt++; if (mem_rd !== 1'b0) $display("FAIL rst_mem_rd: got %b expected 0", mem_rd); else pass_cnt++;
    total_cnt++; if (mem_addr !== '0) $display("FAIL rst_mem_addr: got %0d expected 0", mem_addr); else pass_cnt++;
    total_cnt++; if (miss_count !== 16'd0) $display("FAIL rst_miss_count: got %0d expected 0", miss_count); else pass_cnt++;
    reset = 1'b0;
    model_clear();
    exp_miss = 0;
  endtask

  task automatic test_basic();
    run_req(100, 100, 0, 0, 3);
    run_req(101, 100, 0, 0, 0);
  endtask

  task automatic test_conflict();
    pulse_inv();
    run_req(96, 100, 0, 0, 0);
    run_req(96, 101, 0, 0, 0);
    run_req(96, 100, 0, 0, 0);
  endtask

  task automatic test_out_of_range();
    run_req(640, 0, 0, 0, 0);
    run_req(0, 480, 0, 0, 0);
    run_req(1023, 1023, 0, 0, 0);
    run_req(639, 479, 0, 0, 0);
  endtask

  task automatic test_invalidate();
    pulse_inv();
    run_req(100, 100, 0, 4, 3);
    run_req(100, 100, 0, 0, 0);
    run_req(100, 100, 0, 1, 0);
    run_req(101, 100, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) run_req(200 + i, 50, (i != 11), 0, 0);
  endtask

  task automatic test_reset_mid_fill();
    int saw_ready, saw_rd;
    pulse_inv();
    run_req(100, 100, 0, 0, 0);
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    x = 10'd100; y = 10'd100; request = 1'b1;
    repeat (4) @(posedge clk);
    #1 request = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    total_cnt++; if (miss_count !== 16'd0) $display("FAIL midfill_miss_count: got %0d expected 0", miss_count); else pass_cnt++;
    stray_data  = 16'hFFFF;
    stray_valid = 1'b1;
    @(posedge clk);
    #1 stray_valid = 1'b0;
    saw_ready = 0; saw_rd = 0;
    for (int k = 0; k < 6; k++) begin
      if (ready === 1'b1) saw_ready++;
      if (mem_rd === 1'b1) saw_rd++;
      @(posedge clk);
      #1;
    end
    total_cnt++; if (saw_ready !== 0) $display("FAIL stray_ready: got %0d expected 0", saw_ready); else pass_cnt++;
    total_cnt++; if (saw_rd !== 0) $display("FAIL stray_mem_rd: got %0d expected 0", saw_rd); else pass_cnt++;
    resp_en = 1'b1;
    model_clear();
    exp_miss = 0;
    run_req(100, 100, 0, 0, 0);
  endtask

  task automatic test_random();
    int r, rx, ry;
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 9));
      rx = int'($urandom_range(0, 700));
      ry = (r < 8) ? (r % 3) : 476 + int'($urandom_range(0, 8));
      run_req(rx, ry, bit'($urandom_range(0, 1)), 0, 0);
    end
  endtask

  task automatic test_raster();
    localparam int ROWS = 8;
    pulse_reset();
    for (int ry = 0; ry < ROWS; ry++)
      for (int rx = 0; rx < IMG_W; rx++)
        run_req(rx, ry, 0, 0, int'($urandom_range(1, 3)));
    total_cnt++;
    if (int'(miss_count) !== ROWS * IMG_W / WORD_W)
      $display("FAIL raster_miss_count: got %0d expected %0d", miss_count, ROWS * IMG_W / WORD_W);
    else pass_cnt++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) fb[i] = WORD_W'($urandom);
    fb[4006] = 16'h0010;
    test_reset();
    test_basic();
    test_conflict();
    test_out_of_range();
    test_invalidate();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
    test_raster();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pixel_cache.md
Name: pixel_cache

Overview:
- Serves single-bit pixel reads for the edge search engine from the binary (thresholded) frame buffer.
- The frame buffer is word-organised: WORD_W pixels per word, row-major.
- The block keeps a small direct-mapped cache of frame-buffer words, so sequential scans mostly hit.
- It sits between the edge search engine (x/y/request/pixel/ready) and the frame-buffer read port (mem_*).

Parameters:
- IMG_W, 640, image width in pixels.
- IMG_H, 480, image height in pixels.
- WORD_W, 16, pixels per frame-buffer word. Power of two.
- LINES, 4, number of cache lines. Power of two, at least 2.
- ADDR_W, 15, frame-buffer word address width. Must be at least ceil(log2(IMG_W*IMG_H/WORD_W)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- x  in  10  pixel column requested
- y  in  10  pixel row requested
- request  in  1  read request; held by requester until ready
- pixel  out  1  pixel value; valid only while ready=1
- ready  out  1  one-cycle pulse: pixel is valid
- invalidate  in  1  one-cycle pulse at frame swap; drops all cached lines
- mem_addr  out  ADDR_W  frame-buffer word address
- mem_rd  out  1  one-cycle read strobe
- mem_rdata  in  WORD_W  returned word; bit k = pixel at index word_addr*WORD_W+k
- mem_valid  in  1  one-cycle pulse: mem_rdata valid; arbitrary latency of 1 or more cycles after mem_rd
- miss_count  out  16  saturating count of memory fetches since reset

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, ready=0, pixel=0, mem_rd=0, mem_addr=0, miss_count=0. All line valid bits=0.
- Address arithmetic, computed on the latched x,y:
  - idx = y*IMG_W + x, 19-bit unsigned.
  - waddr = idx / WORD_W; bit = idx % WORD_W.
  - line = waddr % LINES; tag = waddr / LINES.
- State IDLE:
  - If request=1, latch x,y and go to LOOKUP.
  - request is sampled only in IDLE.
  - If request is still high in the IDLE cycle after a response, it is a new request using the current x,y.
- State LOOKUP:
  - Out of range (x>=IMG_W or y>=IMG_H): go to RESPOND with pixel=0. No memory access.
  - Hit (valid[line] and tag match): go to RESPOND with pixel=data[line][bit].
  - Miss: go to FETCH.
- State FETCH:
  - Assert mem_rd=1 for exactly one cycle, with mem_addr=waddr.
  - miss_count increments, saturating at 16'hFFFF.
  - Go to WAIT.
- State WAIT:
  - Hold until mem_valid=1.
  - On mem_valid: write data[line]=mem_rdata, tag[line]=tag, valid[line]=1, then go to RESPOND.
  - pixel=mem_rdata[bit], registered.
- State RESPOND:
  - ready=1 and pixel driven for exactly one cycle, then go to IDLE.
- Latency, request sampled in cycle 0:
  - Hit or out-of-range: ready in cycle 2.
  - Miss with memory latency L: mem_rd in cycle 2, ready in cycle 3+L.
- ready and mem_rd are never high outside RESPOND and FETCH respectively.
- Invalidate:
  - In IDLE or LOOKUP: clears all valid bits that cycle. If it coincides with a LOOKUP, that LOOKUP is evaluated as a miss.
  - In FETCH or WAIT: a pending flag is set. The fill completes and the response is still delivered from mem_rdata, but the filled line is written with valid=0. The pending flag clears all valids on entry to IDLE.
- mem_valid outside WAIT is ignored, including a late return after reset.
- Reset mid-fill: return to IDLE immediately and clear all valids. The outstanding read is abandoned.
- x, y may change while the block is busy; the latched copy is used.

Test Plan:
- Reset, then request (100,100) with memory latency 3 and mem_rdata=16'h0010:
  - mem_rd with mem_addr=4006 two cycles after request; ready 6 cycles after request; pixel=1; miss_count=1.
- Immediately request (101,100), same word, bit 5=0:
  - ready 2 cycles after request; pixel=0; no mem_rd; miss_count stays 1.
- Request (96,100), waddr 4006, line 2, then (96,101), waddr 4046, line 2 with a different tag, then (96,100) again:
  - three misses, each re-fetching; miss_count=4; returned pixels match the supplied words.
- Request (640,0) and (0,480):
  - pixel=0 and ready 2 cycles after each request; no mem_rd.
- Pulse invalidate while in WAIT for (100,100), then re-request (100,100):
  - first response is delivered; second request misses again (mem_rd reissued).
- Assert reset during WAIT, then drive a stray mem_valid in IDLE:
  - no ready; a subsequent request to the same word misses.
- Raster scan of all 640x480 pixels, one row then next:
  - every response is correct; miss_count=19200.
